// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO feeding a UART transmitter. A launch FSM pops one
//             byte at a time, strobes it into the transmitter with a single
//             cycle o_Tx_DV pulse and waits for o_Tx_Done before the next.
//  Options  : UART_TX_FIFO_OVERFLOW_FLAG_EN - when defined, o_Overflow is a
//             sticky flag set by any write dropped while the FIFO is full;
//             when undefined, o_Overflow is tied low and no flag exists.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Wr_En,
    input  logic [DATA_W-1:0] i_Wr_Data,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Tx_DV,
    output logic [DATA_W-1:0] o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Busy,
    output logic              o_Overflow
);

    // Occupancy value meaning "full": 2**ADDR_W in an ADDR_W+1 bit counter.
    localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_e;

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    state_e            r_state;
    logic              r_tx_dv;
    logic [DATA_W-1:0] r_tx_byte;

    logic w_full;
    logic w_empty;
    logic w_wr_accept;
    logic w_pop;

    // Full is judged on the pre-edge count, so a pop in the same cycle
    // never rescues a write attempted while full.
    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = i_Wr_En && !w_full;
    assign w_pop       = (r_state == S_IDLE) && !w_empty && !i_Tx_Active;

    // Storage array: no reset, contents survive a block reset.
    always_ff @(posedge i_Clock) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_Wr_Data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at 2**ADDR_W.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Launch FSM with registered strobe and byte; the byte holds until the
    // next launch so the transmitter may sample it any time after the strobe.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_state   <= S_IDLE;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_byte <= r_mem[r_rd_ptr];
                        r_tx_dv   <= 1'b1;
                        r_state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_tx_dv <= 1'b0;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        r_state <= S_GAP;
                    end
                end
                // One dead cycle lets the transmitter settle back to idle.
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx_dv <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Sticky record of any write lost to a full FIFO; cleared only by reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_Wr_En && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_Overflow = r_overflow;
`else
    assign o_Overflow = 1'b0;
`endif

    assign o_Full    = w_full;
    assign o_Empty   = w_empty;
    assign o_Count   = r_count;
    assign o_Tx_DV   = r_tx_dv;
    assign o_Tx_Byte = r_tx_byte;
    assign o_Busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed bench for uart_tx_fifo with a behavioural transmitter
//             stub (fixed frame length, Active/Done handshake).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int FRAME  = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              tx_dv;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_active;
    logic              tx_done;
    logic              busy;
    logic              overflow;

    logic hold_active;
    logic inject_done;
    logic stub_active;
    logic stub_done;
    int   stub_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q [$];
    int cyc = 0;
    int cyc_done = -1000;
    int spacing_viol = 0;
    int dv_multi = 0;
    int max_count = 0;
    logic prev_dv = 1'b0;

    always #50 clk = ~clk;

    assign tx_active = stub_active | hold_active;
    assign tx_done   = stub_done | inject_done;

    uart_tx_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Wr_En     (wr_en),
        .i_Wr_Data   (wr_data),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Busy      (busy),
        .o_Overflow  (overflow)
    );

    // Transmitter stub: strobe -> Active for FRAME cycles -> one-cycle Done.
    initial begin
        stub_active = 1'b0;
        stub_done   = 1'b0;
        stub_cnt    = 0;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        stub_done <= 1'b0;
        if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                stub_active <= 1'b0;
                stub_done   <= 1'b1;
            end
        end else if (tx_dv) begin
            stub_active <= 1'b1;
            stub_cnt    <= FRAME;
        end
    end

    // Strobe monitor: collects launched bytes, pulse width and spacing.
    always @(negedge clk) begin
        if (tx_done) cyc_done = cyc;
        if (tx_dv && !prev_dv) begin
            rx_q.push_back(tx_byte);
            if (cyc - cyc_done < 3) spacing_viol++;
        end
        if (tx_dv && prev_dv) dv_multi++;
        prev_dv = tx_dv;
        if (int'(count) > max_count) max_count = int'(count);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        spacing_viol = 0;
        dv_multi = 0;
        max_count = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(!busy && empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout, busy=%0b empty=%0b, required idle and empty", name, busy, empty);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tx_dv, tx_byte, busy, overflow, empty, full, count} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset: dv=%0b byte=%h busy=%0b ovf=%0b empty=%0b full=%0b count=%0d, required 0 00 0 0 1 0 0",
                     tx_dv, tx_byte, busy, overflow, empty, full, count);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hAB;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (tx_dv !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL single_after_write: dv=%0b count=%0d empty=%0b, required 0 1 0", tx_dv, count, empty);
        end
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'hAB || count !== 5'd0) begin
            errors++;
            $display("FAIL single_strobe: dv=%0b byte=%h count=%0d, required 1 AB 0", tx_dv, tx_byte, count);
        end
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b0 || busy !== 1'b1 || tx_byte !== 8'hAB) begin
            errors++;
            $display("FAIL single_after_strobe: dv=%0b busy=%0b byte=%h, required 0 1 AB", tx_dv, busy, tx_byte);
        end
        wait_idle(200, "single_idle");
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hAB || dv_multi != 0) begin
            errors++;
            $display("FAIL single_rx: strobes=%0d first=%h wide=%0d, required 1 AB 0",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, dv_multi);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp [3];
        exp = '{8'hAB, 8'hDC, 8'h3F};
        do_reset();
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hAB;
        @(negedge clk); wr_data = 8'hDC;
        @(negedge clk); wr_data = 8'h3F;
        @(negedge clk); wr_en = 1'b0;
        wait_idle(500, "burst_idle");
        checks++;
        if (rx_q.size() != 3) begin
            errors++;
            $display("FAIL burst_count: strobes=%0d, required 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL burst_byte%0d: got %h, required %h", i, rx_q[i], exp[i]);
                end
            end
        end
        checks++;
        if (spacing_viol != 0 || dv_multi != 0) begin
            errors++;
            $display("FAIL burst_spacing: early=%0d wide=%0d, required 0 0", spacing_viol, dv_multi);
        end
    endtask

    task automatic test_full_overflow();
        logic exp_ovf;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        do_reset();
        hold_active = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                checks++;
                if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL full_at16: full=%0b count=%0d ovf=%0b, required 1 16 0", full, count, overflow);
                end
            end
            wr_en = 1'b1; wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== exp_ovf || rx_q.size() != 0) begin
            errors++;
            $display("FAIL full_drop: full=%0b count=%0d ovf=%0b strobes=%0d, required 1 16 %0b 0",
                     full, count, overflow, rx_q.size(), exp_ovf);
        end
        hold_active = 1'b0;
        wait_idle(1000, "full_idle");
        checks++;
        if (rx_q.size() != 16) begin
            errors++;
            $display("FAIL full_drain_count: strobes=%0d, required 16", rx_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (rx_q[i] !== 8'(i)) begin
                    checks++;
                    errors++;
                    $display("FAIL full_drain_byte%0d: got %h, required %h", i, rx_q[i], 8'(i));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        int guard;
        do_reset();
        n = 0;
        guard = 0;
        while (n < 40 && guard < 5000) begin
            @(negedge clk);
            if (!full) begin
                wr_en = 1'b1; wr_data = n[7:0]; n++;
            end else begin
                wr_en = 1'b0;
            end
            guard++;
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(2000, "wrap_idle");
        checks++;
        if (rx_q.size() != 40 || max_count > 16 || max_count < 16) begin
            errors++;
            $display("FAIL wrap_count: strobes=%0d max_count=%0d, required 40 16", rx_q.size(), max_count);
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (rx_q[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL wrap_byte%0d: got %h, required %h", i, rx_q[i], 8'(i));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        hold_active = 1'b1;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h55;
        @(negedge clk); wr_data = 8'h66; hold_active = 1'b0;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (count !== 5'd1 || tx_dv !== 1'b1 || tx_byte !== 8'h55) begin
            errors++;
            $display("FAIL simul_edge: count=%0d dv=%0b byte=%h, required 1 1 55", count, tx_dv, tx_byte);
        end
        wait_idle(300, "simul_idle");
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h66) begin
            errors++;
            $display("FAIL simul_order: strobes=%0d, required 55 then 66", rx_q.size());
        end
    endtask

    task automatic test_done_ignored();
        do_reset();
        hold_active = 1'b1;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h99;
        @(negedge clk); wr_en = 1'b0; inject_done = 1'b1;
        @(negedge clk); inject_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || count !== 5'd1 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL done_ignored: busy=%0b count=%0d strobes=%0d, required 0 1 0", busy, count, rx_q.size());
        end
        hold_active = 1'b0;
        wait_idle(300, "done_ignored_idle");
    endtask

    task automatic test_reset_mid();
        int sz;
        do_reset();
        hold_active = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
        end
        @(negedge clk); wr_en = 1'b0; hold_active = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || count !== 5'd5 || tx_dv !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre: busy=%0b count=%0d dv=%0b, required 1 5 0", busy, count, tx_dv);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || tx_dv !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d empty=%0b dv=%0b busy=%0b, required 0 1 0 0", count, empty, tx_dv, busy);
        end
        sz = rx_q.size();
        repeat (40) @(negedge clk);
        hold_active = 1'b1;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h77;
        @(negedge clk); wr_en = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (rx_q.size() != sz || busy !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL mid_holdoff: strobes=%0d busy=%0b count=%0d, required %0d 0 1", rx_q.size(), busy, count, sz);
        end
        hold_active = 1'b0;
        wait_idle(300, "mid_idle");
        checks++;
        if (rx_q.size() != sz + 1 || rx_q[rx_q.size()-1] !== 8'h77) begin
            errors++;
            $display("FAIL mid_after: strobes=%0d, required %0d ending with 77", rx_q.size(), sz + 1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        hold_active = 1'b0;
        inject_done = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_full_overflow();
        test_wrap();
        test_simultaneous();
        test_done_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered byte source that sits directly upstream of uart_transmitter1.
- Producer logic pushes bytes into a synchronous FIFO.
- A launch FSM pops one byte at a time and hands it to the transmitter via the single-cycle i_Tx_DV/i_Tx_Byte handshake.
- The FSM waits for o_Tx_Done before launching the next byte, so back-to-back bytes stream without producer pacing.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W (16 entries by default).
- DATA_W, 8, byte width; must match the transmitter's byte width.

Ports:
- i_Clock  in  1  system clock; all logic on posedge.
- i_Rst_n  in  1  synchronous active-low reset, sampled on posedge i_Clock.
- i_Wr_En  in  1  push request.
- i_Wr_Data  in  DATA_W  byte to push.
- o_Full  out  1  FIFO holds 2**ADDR_W entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- o_Tx_DV  out  1  one-cycle launch strobe to the transmitter's i_Tx_DV.
- o_Tx_Byte  out  DATA_W  byte to the transmitter's i_Tx_Byte; stable from the strobe until the next launch.
- i_Tx_Active  in  1  from the transmitter's o_Tx_Active.
- i_Tx_Done  in  1  from the transmitter's o_Tx_Done (one-cycle pulse at end of stop bit).
- o_Busy  out  1  high whenever the FSM is not in IDLE.
- o_Overflow  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (i_Rst_n=0 at a posedge):
  - wr_ptr, rd_ptr, count = 0; FSM = IDLE.
  - o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Overflow=0, o_Empty=1, o_Full=0.
  - Memory contents are not cleared.
  - Reset mid-transfer abandons the byte in flight; the transmitter is not reset by this block.
- Write:
  - Accepted when i_Wr_En=1 and count < 2**ADDR_W.
  - mem[wr_ptr] <= i_Wr_Data; wr_ptr increments and wraps modulo 2**ADDR_W.
  - A write while full is dropped. Pointers and count are unchanged.
  - A write while full is dropped even if a pop occurs in the same cycle (full is evaluated on the pre-edge count).
- Pop:
  - Occurs only on the IDLE->LAUNCH transition. rd_ptr increments and wraps.
- Count:
  - count <= count + wr_accepted - pop.
  - A simultaneous accepted write and pop leaves count unchanged.
  - o_Full, o_Empty and o_Count are derived combinationally from the registered count.
- FSM states:
  - IDLE: if count != 0 and i_Tx_Active=0, then o_Tx_Byte <= mem[rd_ptr], o_Tx_DV <= 1, pop, go to LAUNCH. Otherwise stay.
  - LAUNCH (1 cycle): o_Tx_DV <= 0; go to WAIT_DONE.
  - WAIT_DONE: stay until i_Tx_Done=1, then go to GAP.
  - GAP (1 cycle): go to IDLE. Guarantees the transmitter has returned to idle before the next strobe.
- Latency:
  - A write accepted at posedge k into an empty FIFO with the FSM idle and transmitter idle gives o_Tx_DV=1 for the cycle between posedge k+1 and k+2.
  - Exactly one strobe is issued per popped byte.
  - Byte-to-byte spacing is the transmitter frame time plus 3 clocks (Done->GAP->IDLE->LAUNCH).
- Boundary cases:
  - Empty: the FSM waits in IDLE; no strobe is issued.
  - i_Tx_Done asserted outside WAIT_DONE is ignored.
  - i_Tx_Active=1 while in IDLE holds off launch. Covers a transmitter still busy after this block's reset.
  - Wrap-around: after 2**ADDR_W writes and pops, pointers return to 0 and the data order is preserved.

Optional Feature:
- Macro: UART_TX_FIFO_OVERFLOW_FLAG_EN
- Defined:
  - o_Overflow sets to 1 on the posedge where a write is dropped because the FIFO is full.
  - It stays set until reset.
- Undefined:
  - o_Overflow is tied to 0.
  - No flag register is synthesized.
  - Drop behaviour is unchanged.

Test Plan:
- Single byte, with uart_transmitter1 (CLKS_PER_BIT=87, 100 ns clock):
  - Stimulus: write 0xAB.
  - Required: one o_Tx_DV pulse with o_Tx_Byte=0xAB; uart_receiver1 on the serial line reports 0xAB; o_Empty=1 and o_Busy=0 after GAP.
- Burst:
  - Stimulus: write 0xAB, 0xDC, 0x3F on consecutive clocks.
  - Required: three strobes in order AB, DC, 3F, each no earlier than 3 clocks after the prior i_Tx_Done; receiver gets all three.
- Full/overflow, with the transmitter stubbed (i_Tx_Active held 1):
  - Stimulus: write 0x00..0x10 (17 bytes), then release i_Tx_Active.
  - Required: o_Full=1 after the 16th write; 0x10 is dropped; o_Count=16; o_Overflow=1 with the macro, 0 without; then strobes occur with bytes 0x00..0x0F only.
- Wrap-around:
  - Stimulus: stream 40 bytes 0x00..0x27, writing whenever !o_Full.
  - Required: the bytes are strobed out in exact order, with count never exceeding 16.
- Simultaneous write and pop:
  - Stimulus: with count=1 in IDLE, write on the same edge as the launch.
  - Required: o_Count stays at 1 and the data order is preserved.
- Reset mid-operation:
  - Stimulus: assert i_Rst_n=0 for one clock during WAIT_DONE with 5 bytes queued.
  - Required: o_Count=0, o_Empty=1, o_Tx_DV=0, FSM in IDLE; no strobe until the next write and i_Tx_Active=0.
